// File: rtl/sa_controller_if.sv
// Host/array control bundle for sa_controller.
// The host drives START, ROW_VALID and RESULT_ACK. The controller drives the rest.
interface sa_controller_if #(
  parameter int unsigned IDX_W = 3
);
  logic             START;
  logic             ROW_VALID;
  logic             ROW_READY;
  logic             RESULT_ACK;
  logic             EN;
  logic             WRITE;
  logic             RF_EN;
  logic [IDX_W-1:0] IDX;
  logic             BUSY;
  logic             DONE;

  // Host side.
  modport master (
    output START, ROW_VALID, RESULT_ACK,
    input  ROW_READY, EN, WRITE, RF_EN, IDX, BUSY, DONE
  );

  // Controller side.
  modport slave (
    input  START, ROW_VALID, RESULT_ACK,
    output ROW_READY, EN, WRITE, RF_EN, IDX, BUSY, DONE
  );
endinterface

// File: rtl/sa_controller.sv
// Sequencer for the 8x8 systolic array.
// A pass loads ROWS row beats into the register file, waits one settle cycle so the
// last buffered row is committed, and runs the array for COMPUTE_CYCLES. It then
// freezes the array and presents DONE until the host acknowledges.
// Row data flows straight from the host to the array. Only its control is generated here.
module sa_controller #(
  parameter int unsigned ROWS           = 8,
  parameter int unsigned IDX_W          = 3,
  parameter int unsigned COMPUTE_CYCLES = 22,
  parameter int unsigned CNT_W          = 5
) (
  input  logic          CLK,
  input  logic          RST_N,
  sa_controller_if.slave bus
);

  localparam logic [IDX_W-1:0] RowLast = IDX_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(COMPUTE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StCompute,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] cmp_cnt_q, cmp_cnt_d;

  logic             row_ready;
  logic             en;
  logic             write;
  logic             rf_en;
  logic [IDX_W-1:0] idx;
  logic             busy;
  logic             done;

  // State and counter registers. Reset forces IDLE, so every output drops at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      cmp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      cmp_cnt_q <= cmp_cnt_d;
    end
  end

  // Next state, counters, and output decode.
  // EN is the only output that depends on an input, ROW_VALID.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    cmp_cnt_d = cmp_cnt_q;
    row_ready = 1'b0;
    en        = 1'b0;
    write     = 1'b0;
    rf_en     = 1'b0;
    idx       = '0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.START) begin
          state_d = StLoad;
        end
      end

      StLoad: begin
        row_ready = 1'b1;
        write     = 1'b1;
        rf_en     = 1'b1;
        busy      = 1'b1;
        // The array samples DIN on the same edge that completes the handshake.
        en        = bus.ROW_VALID;
        idx       = row_cnt_q;
        // A stall keeps WRITE high. Rewriting the last buffered row to its own index
        // is harmless.
        if (bus.ROW_VALID) begin
          if (row_cnt_q == RowLast) begin
            row_cnt_d = '0;
            state_d   = StSettle;
          end else begin
            row_cnt_d = row_cnt_q + IDX_W'(1);
          end
        end
      end

      StSettle: begin
        // The final row sits in the array buffer. One more write cycle commits it.
        write     = 1'b1;
        rf_en     = 1'b1;
        busy      = 1'b1;
        cmp_cnt_d = '0;
        state_d   = StCompute;
      end

      StCompute: begin
        rf_en = 1'b1;
        busy  = 1'b1;
        if (cmp_cnt_q == CntLast) begin
          state_d = StDone;
        end else begin
          cmp_cnt_d = cmp_cnt_q + CNT_W'(1);
        end
      end

      StDone: begin
        // WRITE high freezes the array so Y holds. RF_EN low blocks register-file writes.
        done  = 1'b1;
        write = 1'b1;
        busy  = 1'b1;
        if (bus.RESULT_ACK) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.ROW_READY = row_ready;
  assign bus.EN        = en;
  assign bus.WRITE     = write;
  assign bus.RF_EN     = rf_en;
  assign bus.IDX       = idx;
  assign bus.BUSY      = busy;
  assign bus.DONE      = done;

  // Row index stays within 0..ROWS-1.
  a_idx_range: assert property (@(posedge CLK) disable iff (!RST_N)
    row_cnt_q <= RowLast);

  // SETTLE lasts exactly one cycle.
  a_settle_one: assert property (@(posedge CLK) disable iff (!RST_N)
    (state_q == StSettle) |=> (state_q == StCompute));

  // EN never fires outside LOAD.
  a_en_load: assert property (@(posedge CLK) disable iff (!RST_N)
    en |-> (state_q == StLoad));

  // The array is never writable and enabled for compute at once while DONE is shown.
  a_done_frozen: assert property (@(posedge CLK) disable iff (!RST_N)
    done |-> (write && !rf_en));

endmodule

// File: tb/tb_sa_controller.sv
// Bench for sa_controller: directed passes plus random host traffic against a timeline model.
module tb_sa_controller;

  localparam int ROWS    = 8;
  localparam int IDX_W   = 3;
  localparam int CC      = 22;
  localparam int CNT_W   = 5;
  localparam int DoneLat = ROWS + 2 + CC;  // START edge to DONE, in cycles

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  sa_controller_if #(.IDX_W(IDX_W)) bus ();

  sa_controller #(
    .ROWS          (ROWS),
    .IDX_W         (IDX_W),
    .COMPUTE_CYCLES(CC),
    .CNT_W         (CNT_W)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;  // index of the last rising edge; "interval c" follows edge c

  // Inputs in effect during the current interval.
  bit in_start, in_valid, in_ack;

  // Timeline model of one pass.
  bit m_active;
  int m_beats;     // accepted row beats in this pass
  int m_t_last;    // edge of the final beat
  int m_t_start;   // edge at which START was taken

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] dut_outs();
    return (32'({bus.ROW_READY, bus.EN, bus.WRITE, bus.RF_EN, bus.BUSY, bus.DONE}) << IDX_W)
           | 32'(bus.IDX);
  endfunction

  // Expected outputs in interval c with ROW_VALID = v.
  // The pass is derived from the beat count and the final-beat edge.
  function automatic logic [31:0] exp_outs(input int c, input bit v);
    bit rr = 0, en = 0, wr = 0, rf = 0, bz = 0, dn = 0;
    int idx = 0;
    if (m_active) begin
      bz = 1;
      if (m_beats < ROWS) begin
        rr = 1; wr = 1; rf = 1; en = v; idx = m_beats;
      end else if (c == m_t_last) begin
        wr = 1; rf = 1;                   // settle
      end else if (c <= m_t_last + CC) begin
        rf = 1;                           // compute
      end else begin
        dn = 1; wr = 1;                   // results held
      end
    end
    return (32'({rr, en, wr, rf, bz, dn}) << IDX_W) | 32'(idx);
  endfunction

  // Apply the inputs of interval cyc-1 at edge cyc.
  task automatic model_edge();
    if (!m_active) begin
      if (in_start) begin
        m_active = 1; m_beats = 0; m_t_start = cyc;
      end
    end else if (m_beats < ROWS) begin
      if (in_valid) begin
        m_beats++;
        if (m_beats == ROWS) m_t_last = cyc;
      end
    end else if ((cyc - 1 > m_t_last + CC) && in_ack) begin
      m_active = 0;
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_beats = 0; m_t_last = 0; m_t_start = 0;
    in_start = 0; in_valid = 0; in_ack = 0;
    bus.START = 0; bus.ROW_VALID = 0; bus.RESULT_ACK = 0;
  endtask

  // One clock: advance the model, drive new inputs, check all outputs.
  task automatic cycle(input bit s, input bit v, input bit a);
    @(posedge CLK);
    cyc++;
    model_edge();
    #1;
    in_start = s; in_valid = v; in_ack = a;
    bus.START = s; bus.ROW_VALID = v; bus.RESULT_ACK = a;
    #1;
    check_eq("outs", dut_outs(), exp_outs(cyc, v));
  endtask

  // One pass from START to DONE. Mode 1 stalls three cycles after beat 4 and
  // drives ignored ACK during load and ignored START during compute.
  task automatic run_pass(input int mode, input string tag, input int want);
    bit seen = 0;
    int lat  = -1;
    bit s, v, a;
    cycle(1, 0, 0);
    for (int k = 1; k <= 80 && !seen; k++) begin
      v = 1; s = 0; a = 0;
      if (mode == 1) begin
        v = !(k >= 6 && k <= 8);
        a = (k <= 11);
        s = (k >= 14 && k <= 30);
      end
      cycle(s, v, a);
      if (bus.DONE === 1'b1) begin
        seen = 1;
        lat  = cyc + 1 - m_t_start;  // interval after edge c is cycle c+1 from START
      end
    end
    check_eq(tag, 32'(lat), 32'(want));
  endtask

  // Hold results, then ACK together with START; the START must not begin a pass.
  task automatic hold_and_ack();
    for (int k = 0; k < 10; k++) cycle(0, 0, 0);
    cycle(1, 0, 1);
    cycle(0, 0, 0);
    check_eq("ack_start_busy", 32'(bus.BUSY), 32'd0);
    cycle(0, 1, 0);
    check_eq("no_queued_start", 32'(bus.ROW_READY), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    bit reached;
    model_reset();

    // Reset with START held high.
    bus.START = 1;
    #3;
    check_eq("rst_outs", dut_outs(), 32'd0);
    @(posedge CLK);
    #2;
    check_eq("rst_outs_edge", dut_outs(), 32'd0);
    bus.START = 0;
    @(negedge CLK);
    RST_N = 1;

    // Back-to-back load, then result hold and ACK+START.
    run_pass(0, "b2b_done_cycle", DoneLat);
    hold_and_ack();

    // Stalled load with ignored inputs.
    run_pass(1, "stall_done_cycle", DoneLat + 3);
    hold_and_ack();

    // Asynchronous reset while IDX=3.
    cycle(1, 0, 0);
    reached = 0;
    for (int k = 0; k < 20 && !reached; k++) begin
      cycle(0, 1, 0);
      if (m_active && m_beats == 3) reached = 1;
    end
    check_eq("reach_idx3", 32'(bus.IDX), 32'd3);
    #2;
    RST_N = 0;
    #1;
    check_eq("async_rst_outs", dut_outs(), 32'd0);
    model_reset();
    @(posedge CLK);
    #3;
    RST_N = 1;
    run_pass(0, "post_rst_done_cycle", DoneLat);
    hold_and_ack();

    // Random host traffic.
    for (int k = 0; k < 2500; k++) begin
      cycle(bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
